// File: rtl/seg7_scan.sv
// Scanned hex seven-segment driver: frame-synchronous value loading, leading-zero blanking, PWM dimming.
// Optional decimal points are enabled by defining SEG7_DP_EN.

module seg7_lane #(
  parameter int LANE = 0
) (
  input  logic [3:0] nib,
  input  logic       hi_zero,
  input  logic       blank_lz,
  output logic [6:0] font,
  output logic       blank,
  output logic       zero_out
);
  // zero_out: this nibble and every more-significant one are zero
  assign zero_out = hi_zero && (nib == 4'h0);
  assign blank    = (LANE != 0) && blank_lz && zero_out;

  always_comb begin
    font = 7'h00;
    case (nib)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      4'hF: font = 7'h71;
      default: font = 7'h00;
    endcase
  end
endmodule

module seg7_scan #(
  parameter int DIGITS   = 2,
  parameter int DIV_BITS = 16,
  parameter int PWM_BITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  output logic                  ready,
  input  logic                  blank_lz,
  input  logic [PWM_BITS-1:0]   brightness,
`ifdef SEG7_DP_EN
  input  logic [DIGITS-1:0]     dp_mask,
  output logic                  dp,
`endif
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  overrun
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  logic [DIV_BITS-1:0]     cnt;
  logic [IDX_W-1:0]        idx;
  logic                    tick, frame_end, pwm_on, cur_blank;
  logic [DIGITS-1:0][3:0]  pending, shown;
  logic [DIGITS-1:0][6:0]  lane_font;
  logic [DIGITS-1:0]       lane_blank;
  logic [DIGITS:0]         lane_zero;

  assign tick      = &cnt;
  assign frame_end = tick && (idx == LAST);
  assign pwm_on    = cnt[DIV_BITS-1 -: PWM_BITS] < brightness;
  assign cur_blank = lane_blank[idx];
  assign lane_zero[DIGITS] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_lane
      seg7_lane #(.LANE(i)) u_lane (
        .nib      (shown[i]),
        .hi_zero  (lane_zero[i+1]),
        .blank_lz (blank_lz),
        .font     (lane_font[i]),
        .blank    (lane_blank[i]),
        .zero_out (lane_zero[i])
      );
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (tick) idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  // Transfer tests the pre-edge ready, so a load accepted on a frame end waits a full frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      shown   <= '0;
      ready   <= 1'b1;
      overrun <= 1'b0;
    end else begin
      if (load && ready) begin
        pending <= value;
        ready   <= 1'b0;
      end else if (load) begin
        overrun <= 1'b1;
      end
      if (frame_end && !ready) begin
        shown <= pending;
        ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg     <= '0;
      dig_sel <= '0;
    end else begin
      seg     <= cur_blank ? 7'h00 : lane_font[idx];
      dig_sel <= (!cur_blank && pwm_on) ? (DIGITS'(1) << idx) : '0;
    end
  end

`ifdef SEG7_DP_EN
  logic [DIGITS-1:0] pending_dp, shown_dp;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_dp <= '0;
      shown_dp   <= '0;
      dp         <= 1'b0;
    end else begin
      if (load && ready) pending_dp <= dp_mask;
      if (frame_end && !ready) shown_dp <= pending_dp;
      dp <= shown_dp[idx] && !cur_blank;
    end
  end
`endif
endmodule
